dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data memory between the CPU data port and an auxiliary master (debug/loader/DMA) port. It sits between `cpu` and `data_mem` and sequences every access through a small FSM. It converts the memory's busy indication into the CPU clock-stall signal that gates `clk_proc`. The CPU wins contention; a starvation counter guarantees the auxiliary port a slot.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 4, consecutive contended CPU grants before the aux port is forced to win (≥1)
---
- `clk`  in  1  system clock (ungated); all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `cpu_addr` / `cpu_wdata`  in  ADDR_W / DATA_W  CPU data request fields
- `cpu_memread` / `cpu_memwrite`  in  1 / 1  CPU strobes; either high = CPU request (`cpu_req`)
- `cpu_sign_mask`  in  4  CPU byte/sign mask
- `cpu_rdata`  out  DATA_W  read data to CPU
- `cpu_stall`  out  1  holds the CPU clock high while its access is pending
- `aux_req`  in  1  aux request; held until `aux_done`
- `aux_we`  in  1  1 = write, 0 = read
- `aux_addr` / `aux_wdata` / `aux_sign_mask`  in  ADDR_W / DATA_W / 4  aux request fields
- `aux_gnt`  out  1  aux access owns the memory
- `aux_done`  out  1  one-cycle completion pulse
- `aux_rdata`  out  DATA_W  registered aux read data
- `mem_addr` / `mem_wdata` / `mem_sign_mask`  out  ADDR_W / DATA_W / 4  to data memory
- `mem_memread` / `mem_memwrite`  out  1 / 1  to data memory
- `mem_rdata`  in  DATA_W  from data memory
- `mem_busy`  in  1  data memory's `clk_stall`; access is incomplete while high

## Operation
- FSM states: IDLE, CPU, AUX.
- IDLE, arbitration:
  - `cpu_req` and (!`aux_req` or `starve_cnt` < STARVE_LIMIT) → CPU.
  - Otherwise `aux_req` → AUX.
  - Otherwise remain in IDLE.
- CPU / AUX: drive the owner's fields onto `mem_*`. Completion is the first cycle in the state with `mem_busy` = 0; next state is IDLE.
- IDLE drives all `mem_*` to 0, so no strobes are issued.
- `mem_*` is a combinational mux selected by the state register.
- Strobes pass through unchanged (read+write both high forwarded as given).
- `cpu_stall` = `cpu_req` && !(state==CPU && !`mem_busy`). It is forced to 0 while `rst_n` is low.
- `cpu_rdata` = `mem_rdata`, combinational pass-through.
- `aux_gnt` = (state==AUX).
- On AUX completion: `aux_rdata` ← `mem_rdata` (read only; unchanged on a write), and `aux_done` pulses in the following cycle.
- Aux rules:
  - Fields must be held stable while `aux_req` is high.
  - `aux_req` may drop only while `aux_gnt` = 0.
  - Dropping `aux_req` during AUX does not abort the access.
- `starve_cnt` (0..STARVE_LIMIT, saturating):
  - +1 on each transition IDLE→CPU with `aux_req` high.
  - Cleared on IDLE→AUX, or whenever `aux_req` = 0.
- A CPU request arriving during AUX stalls until AUX completes and the IDLE arbitration that follows.

## Timing
- Reset values: state IDLE; `starve_cnt` 0; `aux_gnt` 0; `aux_done` 0; `aux_rdata` 0; `mem_memread`/`mem_memwrite` 0; `cpu_stall` 0.
- Minimum access: 2 cycles (IDLE arbitration + 1 memory cycle). Each `mem_busy` cycle adds 1.
- CPU read with `cpu_req` first seen in cycle 0 and `mem_busy` = 0:
  - `cpu_stall` = 1 in cycle 0, 0 in cycle 1.
  - The CPU samples `cpu_rdata` at the end of cycle 1.
- Back-to-back accesses always pass through one IDLE cycle, so there is never a same-cycle handover.
- Simultaneous requests in IDLE: CPU wins unless `starve_cnt` == STARVE_LIMIT.
- `rst_n` low mid-access: next edge goes to IDLE and strobes drop. An aborted aux access gets no `aux_done`.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum (IDLE/CPU/AUX),
  - `ADDR_W`/`DATA_W` defaults,
  - the mask width constant (4).
- One natural sub-module, `arb_starve_ctr`: a saturating counter with inc/clr inputs and a `limit_hit` output.

## Test plan
- CPU read of addr 0x1000, `mem_busy` = 0, `mem_rdata` = 0xDEADBEEF → `cpu_stall` high exactly 1 cycle; `cpu_rdata` = 0xDEADBEEF in the completion cycle.
- CPU write with `mem_busy` high 3 cycles → `cpu_stall` high 4 cycles; `mem_memwrite` high 3+1 cycles with stable addr/data.
- Aux read of 0x2004 (`mem_rdata` 0x12345678), idle CPU → `aux_gnt` 1 cycle, then `aux_done` pulse with `aux_rdata` = 0x12345678.
- Continuous CPU requests plus `aux_req`, STARVE_LIMIT = 4 → exactly 4 CPU grants, then an AUX grant; counter returns to 0.
- CPU request raised mid-AUX → `mem_*` stays on aux fields until completion, CPU granted after one IDLE cycle.
- `rst_n` low during AUX with `mem_busy` high → next cycle state IDLE, strobes 0, no `aux_done`, all outputs at reset values.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter slice.
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   MASK_W                  : width of the byte/sign mask
//   arb_state_e             : arbiter FSM states (IDLE / CPU / AUX)
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int MASK_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_AUX  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// arb_starve_ctr
// Saturating counter (0..LIMIT) tracking how many times in a row the CPU won
// arbitration while the aux port was waiting.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   inc_i        : count one more contended CPU grant (saturates at LIMIT)
//   clr_i        : return to zero; wins over inc_i
//   limit_hit_o  : counter has reached LIMIT, aux must win next arbitration
// -----------------------------------------------------------------------------
module arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic limit_hit_o
);

  localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign limit_hit_o = (cnt_q == CNT_W'(LIMIT));

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !limit_hit_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data memory between the CPU data port and an auxiliary
// master. Every access is sequenced IDLE -> owner -> IDLE; the CPU wins
// contention unless the aux port has lost STARVE_LIMIT times in a row.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   cpu_*                           : CPU request fields / strobes, read data
//   cpu_stall                       : holds CPU clock while its access pends
//   aux_req/we/addr/wdata/sign_mask : aux request (held until aux_done)
//   aux_gnt, aux_done, aux_rdata    : aux ownership, completion pulse, data
//   mem_*                           : data-memory side; mem_busy extends access
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU data port
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_memread,
  input  logic              cpu_memwrite,
  input  logic [MASK_W-1:0] cpu_sign_mask,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  // Auxiliary master port
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  input  logic [MASK_W-1:0] aux_sign_mask,
  output logic              aux_gnt,
  output logic              aux_done,
  output logic [DATA_W-1:0] aux_rdata,
  // Data memory port
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_sign_mask,
  output logic              mem_memread,
  output logic              mem_memwrite,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy
);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;
  logic              aux_done_q, aux_done_d;

  logic cpu_req;
  logic limit_hit;
  logic grant_cpu;
  logic grant_aux;
  logic aux_complete;

  assign cpu_req      = cpu_memread | cpu_memwrite;
  assign aux_complete = (state_q == ST_AUX) && !mem_busy;

  // Arbitration only happens in IDLE; the starve counter lets aux through
  // once the CPU has won LIMIT contended rounds.
  assign grant_cpu = (state_q == ST_IDLE) && cpu_req && (!aux_req || !limit_hit);
  assign grant_aux = (state_q == ST_IDLE) && !grant_cpu && aux_req;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_i       (grant_cpu && aux_req),
    .clr_i       (!aux_req || grant_aux),
    .limit_hit_o (limit_hit)
  );

  // Next-state logic and aux completion bookkeeping.
  always_comb begin
    state_d     = state_q;
    aux_rdata_d = aux_rdata_q;
    aux_done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_cpu) begin
          state_d = ST_CPU;
        end else if (grant_aux) begin
          state_d = ST_AUX;
        end
      end
      ST_CPU: begin
        if (!mem_busy) begin
          state_d = ST_IDLE;
        end
      end
      ST_AUX: begin
        if (!mem_busy) begin
          state_d    = ST_IDLE;
          aux_done_d = 1'b1;
          if (!aux_we) begin
            aux_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      aux_rdata_q <= '0;
      aux_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      aux_rdata_q <= aux_rdata_d;
      aux_done_q  <= aux_done_d;
    end
  end

  // Memory-side mux keyed purely on the registered owner; IDLE issues nothing.
  always_comb begin
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_sign_mask = '0;
    mem_memread   = 1'b0;
    mem_memwrite  = 1'b0;
    unique case (state_q)
      ST_CPU: begin
        mem_addr      = cpu_addr;
        mem_wdata     = cpu_wdata;
        mem_sign_mask = cpu_sign_mask;
        mem_memread   = cpu_memread;
        mem_memwrite  = cpu_memwrite;
      end
      ST_AUX: begin
        mem_addr      = aux_addr;
        mem_wdata     = aux_wdata;
        mem_sign_mask = aux_sign_mask;
        mem_memread   = !aux_we;
        mem_memwrite  = aux_we;
      end
      default: ;
    endcase
  end

  // The CPU is released only in the cycle its own access completes; the
  // reset term keeps the gated CPU clock running while the block is held.
  assign cpu_stall = rst_n && cpu_req && !((state_q == ST_CPU) && !mem_busy);
  assign cpu_rdata = mem_rdata;
  assign aux_gnt   = (state_q == ST_AUX);
  assign aux_done  = aux_done_q;
  assign aux_rdata = aux_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level model of who owns the memory and what each
// output must show.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic          clk, rst_n;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_memread, cpu_memwrite, cpu_stall;
  logic [3:0]    cpu_sign_mask;
  logic          aux_req, aux_we, aux_gnt, aux_done;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_wdata, aux_rdata;
  logic [3:0]    aux_sign_mask;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_sign_mask;
  logic          mem_memread, mem_memwrite, mem_busy;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_memread(cpu_memread),
    .cpu_memwrite(cpu_memwrite), .cpu_sign_mask(cpu_sign_mask),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_sign_mask(aux_sign_mask), .aux_gnt(aux_gnt), .aux_done(aux_done),
    .aux_rdata(aux_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sign_mask(mem_sign_mask),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: who currently holds the memory (0 none, 1 cpu, 2 aux),
  // how many contended CPU wins in a row, and the aux result registers.
  int          m_owner  = 0;
  int          m_starve = 0;
  logic [31:0] m_aux_rdata = '0;
  logic        m_aux_done  = 1'b0;

  // Observations from the last cycle, used to steer stimulus and counters.
  bit obs_stall, obs_gnt, obs_done, obs_cpu_complete, cpu_done_prev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are set before calling; compares this cycle, then crosses one edge.
  task automatic tick();
    logic        creq, e_stall, e_rd, e_wr, n_done;
    logic [31:0] e_addr, e_wdata, n_rdata;
    logic [3:0]  e_mask;
    bit          fin;
    int          n_owner, n_starve;
    #1;
    creq    = cpu_memread | cpu_memwrite;
    e_stall = rst_n && creq && !(m_owner == 1 && !mem_busy);
    e_addr = '0; e_wdata = '0; e_mask = '0; e_rd = 1'b0; e_wr = 1'b0;
    if (m_owner == 1) begin
      e_addr = cpu_addr; e_wdata = cpu_wdata; e_mask = cpu_sign_mask;
      e_rd = cpu_memread; e_wr = cpu_memwrite;
    end else if (m_owner == 2) begin
      e_addr = aux_addr; e_wdata = aux_wdata; e_mask = aux_sign_mask;
      e_rd = !aux_we; e_wr = aux_we;
    end
    check("cpu_stall", cpu_stall, e_stall);
    check("cpu_rdata", cpu_rdata, mem_rdata);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    check("mem_sign_mask", mem_sign_mask, e_mask);
    check("mem_memread", mem_memread, e_rd);
    check("mem_memwrite", mem_memwrite, e_wr);
    check("aux_gnt", aux_gnt, m_owner == 2);
    check("aux_done", aux_done, m_aux_done);
    check("aux_rdata", aux_rdata, m_aux_rdata);
    obs_stall        = cpu_stall;
    obs_gnt          = aux_gnt;
    obs_done         = aux_done;
    obs_cpu_complete = rst_n && creq && !cpu_stall;
    cpu_done_prev    = rst_n && creq && !e_stall;

    n_owner = m_owner; n_starve = m_starve; n_done = 1'b0; n_rdata = m_aux_rdata;
    if (!rst_n) begin
      n_owner = 0; n_starve = 0; n_rdata = '0;
    end else if (m_owner == 0) begin
      if (creq && (!aux_req || m_starve < LIMIT)) begin
        n_owner  = 1;
        n_starve = aux_req ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
      end else if (aux_req) begin
        n_owner  = 2;
        n_starve = 0;
      end else begin
        n_starve = 0;
      end
    end else begin
      fin = !mem_busy;
      if (fin) n_owner = 0;
      if (!aux_req) n_starve = 0;
      if (fin && m_owner == 2) begin
        n_done = 1'b1;
        if (!aux_we) n_rdata = mem_rdata;
      end
    end
    @(posedge clk);
    #1;
    m_owner = n_owner; m_starve = n_starve; m_aux_done = n_done; m_aux_rdata = n_rdata;
  endtask

  task automatic idle_inputs();
    cpu_memread = 1'b0; cpu_memwrite = 1'b0; aux_req = 1'b0; mem_busy = 1'b0;
  endtask

  // Random traffic obeying both masters' hold rules.
  task automatic drive_random();
    rst_n     = ($urandom_range(0, 149) != 0);
    mem_busy  = ($urandom_range(0, 3) == 0);
    mem_rdata = $urandom;
    if (!(cpu_memread | cpu_memwrite) || cpu_done_prev) begin
      if ($urandom_range(0, 1) == 1) begin
        cpu_addr = $urandom; cpu_wdata = $urandom; cpu_sign_mask = 4'($urandom);
        cpu_memread  = $urandom_range(0, 1) == 1;
        cpu_memwrite = !cpu_memread || ($urandom_range(0, 7) == 0);
      end else begin
        cpu_memread = 1'b0; cpu_memwrite = 1'b0;
      end
    end
    if (aux_req && m_aux_done) begin
      aux_req = 1'b0;
    end else if (!aux_req && $urandom_range(0, 3) == 0) begin
      aux_req = 1'b1; aux_we = $urandom_range(0, 1) == 1;
      aux_addr = $urandom; aux_wdata = $urandom; aux_sign_mask = 4'($urandom);
    end
  endtask

  initial begin
    int n, m, seen;
    rst_n = 1'b0; idle_inputs();
    cpu_addr = '0; cpu_wdata = '0; cpu_sign_mask = '0;
    aux_we = 1'b0; aux_addr = '0; aux_wdata = '0; aux_sign_mask = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values, with a CPU strobe up to show cpu_stall is held at 0.
    cpu_memread = 1'b1;
    tick();
    rst_n = 1'b1; cpu_memread = 1'b0;
    tick();

    // T1: CPU read, no wait states.
    cpu_addr = 32'h1000; cpu_memread = 1'b1; cpu_sign_mask = 4'hF; mem_rdata = 32'hDEADBEEF;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs_stall) n++;
      if (obs_cpu_complete) break;
    end
    check("t1_stall_cycles", n, 1);
    check("t1_completed", obs_cpu_complete, 1);
    cpu_memread = 1'b0;
    tick();

    // T2: CPU write with mem_busy high for 3 cycles.
    cpu_addr = 32'h1230; cpu_wdata = 32'hCAFEF00D; cpu_memwrite = 1'b1;
    n = 0; m = 0;
    for (int i = 0; i < 20; i++) begin
      mem_busy = (i >= 1 && i <= 3);
      #1;
      if (mem_memwrite) m++;
      tick();
      if (obs_stall) n++;
      if (obs_cpu_complete) break;
    end
    check("t2_stall_cycles", n, 4);
    check("t2_memwrite_cycles", m, 4);
    cpu_memwrite = 1'b0; mem_busy = 1'b0;
    tick();

    // T3: aux read with an idle CPU.
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h2004; aux_sign_mask = 4'h3;
    mem_rdata = 32'h12345678;
    n = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_aux_done) aux_req = 1'b0;
      tick();
      if (obs_gnt) n++;
      if (obs_done) begin seen = 1; break; end
    end
    check("t3_gnt_cycles", n, 1);
    check("t3_done_seen", seen, 1);
    check("t3_aux_rdata", aux_rdata, 32'h12345678);
    aux_req = 1'b0; mem_rdata = 32'h0BAD0BAD;
    tick();

    // T4: continuous CPU plus aux: LIMIT CPU grants then aux, twice.
    for (int round = 0; round < 2; round++) begin
      cpu_addr = 32'h40 + 32'(round); cpu_memread = 1'b1;
      aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h5000; aux_wdata = 32'hA5A5A5A5;
      n = 0; seen = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (obs_gnt) begin seen = 1; break; end
        if (obs_cpu_complete) n++;
      end
      check("t4_cpu_grants", n, LIMIT);
      check("t4_aux_granted", seen, 1);
      aux_req = 1'b0; cpu_memread = 1'b0;
      repeat (2) tick();
    end

    // T5: CPU request raised while aux owns the memory.
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h3000; aux_wdata = 32'h11223344;
    tick();
    cpu_addr = 32'h7000; cpu_wdata = 32'h55667788; cpu_memwrite = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      mem_busy = (i < 2);
      if (m_aux_done) aux_req = 1'b0;
      tick();
      if (obs_stall) n++;
      if (obs_cpu_complete) break;
    end
    check("t5_cpu_stall_cycles", n, 4);
    cpu_memwrite = 1'b0; aux_req = 1'b0; mem_busy = 1'b0;
    tick();

    // T6: reset while aux is waiting on a busy memory.
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h2008; mem_busy = 1'b1;
    tick();
    tick();
    check("t6_gnt_before_reset", obs_gnt, 1);
    rst_n = 1'b0;
    tick();
    aux_req = 1'b0; cpu_memread = 1'b1;
    tick();
    rst_n = 1'b1; cpu_memread = 1'b0; mem_busy = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs_done) seen = 1;
    end
    check("t6_no_aux_done", seen, 0);

    // Randomized traffic.
    idle_inputs();
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
